// File: rtl/nibble_bus_demux.sv
// Receiver for a '157-style nibble-multiplexed bus: steers the upstream selector,
// samples low then high nibble, and presents the assembled word over valid/ready.
module nibble_bus_demux #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   bus_in,
   output logic               sel_out,
   output logic               en_n_out,
   output logic               busy,
   output logic [2*WIDTH-1:0] data_out,
   output logic               valid,
   input  logic               ready
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LO_WAIT = 2'd1;
   localparam logic [1:0] HI_WAIT = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] lo_nibble;

   // Outputs are registered alongside the state so they always reflect the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lo_nibble <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         sel_out   <= 1'b0;
         en_n_out  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LO_WAIT;
                  cnt      <= SETTLE_CNT;
                  en_n_out <= 1'b0;
                  sel_out  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            LO_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  lo_nibble <= bus_in;
                  cnt       <= SETTLE_CNT;
                  sel_out   <= 1'b1;
                  state     <= HI_WAIT;
               end
            end
            HI_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Whole word lands in one edge, so no partial word is ever visible.
                  data_out <= {bus_in, lo_nibble};
                  valid    <= 1'b1;
                  sel_out  <= 1'b0;
                  en_n_out <= 1'b1;
                  busy     <= 1'b0;
                  state    <= HOLD;
               end
            end
            default: begin
               if (ready) begin
                  valid <= 1'b0;
                  if (start) begin
                     state    <= LO_WAIT;
                     cnt      <= SETTLE_CNT;
                     en_n_out <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_bus_demux.sv
// Directed bench for nibble_bus_demux with a behavioural upstream '157 selector.
module tb_nibble_bus_demux;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] bus_in;
   logic       sel_out;
   logic       en_n_out;
   logic       busy;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;

   logic [3:0] src_a;
   logic [3:0] src_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Upstream '157: output forced low while disabled, else A (sel=0) or B (sel=1).
   assign bus_in = en_n_out ? 4'b0000 : (sel_out ? src_b : src_a);

   nibble_bus_demux #(.WIDTH(4), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus_in(bus_in),
      .sel_out(sel_out), .en_n_out(en_n_out), .busy(busy),
      .data_out(data_out), .valid(valid), .ready(ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; src_a = 4'b1010; src_b = 4'b0101;
      repeat (3) step();
      checks++; if (sel_out !== 1'b0)  begin failures++; $display("FAIL reset_sel got=%b exp=0", sel_out); end
      checks++; if (en_n_out !== 1'b1) begin failures++; $display("FAIL reset_en_n got=%b exp=1", en_n_out); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({en_n_out, sel_out, busy, valid} !== 4'b1000) begin
            failures++; $display("FAIL idle_quiet cyc=%0d got en_n/sel/busy/valid=%b exp=1000", i, {en_n_out, sel_out, busy, valid});
         end
      end
   endtask

   task automatic test_basic();
      logic exp_sel;
      logic exp_en_n;
      logic exp_busy;
      logic exp_valid;
      src_a = 4'b1010; src_b = 4'b0101; ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      // k counts edges after the start edge; word completes on edge 4.
      for (int k = 0; k <= 4; k++) begin
         exp_en_n  = (k == 4);
         exp_sel   = (k == 2 || k == 3);
         exp_busy  = (k < 4);
         exp_valid = (k == 4);
         checks++;
         if ({en_n_out, sel_out, busy, valid} !== {exp_en_n, exp_sel, exp_busy, exp_valid}) begin
            failures++;
            $display("FAIL basic_ctrl k=%0d got en_n/sel/busy/valid=%b exp=%b", k,
                     {en_n_out, sel_out, busy, valid}, {exp_en_n, exp_sel, exp_busy, exp_valid});
         end
         if (k < 4) step();
      end
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL basic_data got=%h exp=5a", data_out); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) begin
         start = (i % 3 == 0);
         step();
         checks++;
         if ({valid, busy, en_n_out} !== 3'b101 || data_out !== 8'h5A) begin
            failures++;
            $display("FAIL hold_stable cyc=%0d got valid/busy/en_n=%b data=%h exp=101 data=5a", i, {valid, busy, en_n_out}, data_out);
         end
      end
      start = 1'b0; ready = 1'b1;
      step();
      ready = 1'b0;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL accept_valid got=%b exp=0", valid); end
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL accept_data_kept got=%h exp=5a", data_out); end
      step();
      checks++;
      if ({en_n_out, busy, valid} !== 3'b100) begin
         failures++; $display("FAIL accept_idle got en_n/busy/valid=%b exp=100", {en_n_out, busy, valid});
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_valid;
      logic [7:0] exp_data;
      src_a = 4'b1010; src_b = 4'b0101;
      ready = 1'b1; start = 1'b1;
      step();
      // Words complete on edges 4, 9 and 14 after the first start edge.
      for (int c = 0; c <= 14; c++) begin
         exp_valid = (c == 4 || c == 9 || c == 14);
         exp_data  = (c >= 9 && c < 14) ? 8'hC3 : 8'h5A;
         checks++;
         if (valid !== exp_valid || data_out !== exp_data) begin
            failures++;
            $display("FAIL b2b c=%0d got valid=%b data=%h exp valid=%b data=%h", c, valid, data_out, exp_valid, exp_data);
         end
         if (c == 4) begin src_a = 4'b0011; src_b = 4'b1100; end
         if (c == 9) begin src_a = 4'b1010; src_b = 4'b0101; end
         if (c == 14) start = 1'b0;
         if (c < 14) step();
      end
      step();
      checks++;
      if ({en_n_out, busy, valid} !== 3'b100) begin
         failures++; $display("FAIL b2b_end got en_n/busy/valid=%b exp=100", {en_n_out, busy, valid});
      end
      ready = 1'b0;
   endtask

   task automatic test_disabled_bus();
      int valid_cycles;
      valid_cycles = 0;
      src_a = 4'b1010; src_b = 4'b0101; ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (valid) begin
            valid_cycles++;
            checks++;
            if (data_out !== 8'h5A) begin failures++; $display("FAIL disabled_bus_data got=%h exp=5a", data_out); end
         end
         step();
      end
      checks++; if (valid_cycles != 1) begin failures++; $display("FAIL disabled_bus_pulses got=%0d exp=1", valid_cycles); end
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL disabled_bus_hold got=%h exp=5a", data_out); end
      ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int valid_seen;
      valid_seen = 0;
      src_a = 4'b1010; src_b = 4'b0101; ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      checks++; if ({sel_out, busy} !== 2'b11) begin failures++; $display("FAIL mid_in_hi got sel/busy=%b exp=11", {sel_out, busy}); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sel_out, en_n_out, busy, valid} !== 4'b0100 || data_out !== 8'h00) begin
         failures++;
         $display("FAIL mid_async got sel/en_n/busy/valid=%b data=%h exp=0100 data=00", {sel_out, en_n_out, busy, valid}, data_out);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         if (valid) valid_seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (valid) valid_seen++;
      end
      checks++; if (valid_seen != 0) begin failures++; $display("FAIL mid_no_valid got=%0d exp=0", valid_seen); end
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      checks++;
      if (valid !== 1'b1 || data_out !== 8'h5A) begin
         failures++; $display("FAIL mid_recover got valid=%b data=%h exp valid=1 data=5a", valid, data_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_disabled_bus();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_bus_demux.md
# nibble_bus_demux

Receiving end of a '157-style nibble-multiplexed bus. The block drives the select and active-low enable of an upstream quad 2-to-1 selector, samples the shared WIDTH-bit bus once per phase, and reassembles the low and high nibbles into one 2*WIDTH-bit word. The assembled word is delivered with a valid/ready handshake. It sits between narrow TTL-modelled datapath buses and the CPU's byte-wide registers.

## Interface
- WIDTH, default 4: width of the multiplexed bus; the output is 2*WIDTH bits.
- SETTLE, default 1, legal range 0..15: extra wait cycles after each select change before sampling, to cover the upstream propagation delay.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one two-phase transfer; sampled only in IDLE (and in HOLD when the word is accepted).
- bus_in  in  WIDTH  multiplexed bus (upstream selector output).
- sel_out  out  1  upstream select: 0 = low-nibble source, 1 = high-nibble source.
- en_n_out  out  1  upstream enable, active-low; 0 only while sampling phases run.
- busy  out  1  high in LO_WAIT and HI_WAIT.
- data_out  out  2*WIDTH  assembled word {high, low}.
- valid  out  1  data_out holds a new word; held until accepted.
- ready  in  1  consumer accepts the word when valid && ready.

## Operation
- All outputs and the FSM are registered. Reset (rst_n=0, asynchronous) forces: state=IDLE, sel_out=0, en_n_out=1, busy=0, valid=0, data_out=0, low staging register=0, counter=0.
- FSM states: IDLE, LO_WAIT, HI_WAIT, HOLD.
- IDLE: en_n_out=1, sel_out=0, busy=0, valid=0.
  - start=1 → LO_WAIT; load the counter with SETTLE.
- LO_WAIT: en_n_out=0, sel_out=0, busy=1.
  - Counter≠0: decrement it.
  - Counter=0: capture bus_in into the low staging register → HI_WAIT; reload the counter with SETTLE.
- HI_WAIT: en_n_out=0, sel_out=1, busy=1.
  - Counter≠0: decrement it.
  - Counter=0: data_out ← {bus_in, low staging}; valid ← 1 → HOLD.
- HOLD: en_n_out=1, sel_out=0, busy=0, valid=1, data_out stable.
  - valid && ready with start=1 → LO_WAIT (back-to-back transfer).
  - valid && ready with start=0 → IDLE.
  - ready=0 → stay in HOLD indefinitely.
- data_out changes only on the HI_WAIT capture edge, so a partial word is never visible. After valid drops, data_out keeps the last word.
- start is ignored in LO_WAIT, HI_WAIT, and in HOLD while ready=0. There is no queuing.
- Reset asserted mid-transfer discards the partial capture. Outputs take their reset values immediately, without waiting for a clock edge.
- The counter is 4 bits wide. SETTLE values outside 0..15 are illegal.

## Timing
- Each phase lasts SETTLE+1 cycles. bus_in is sampled on the last edge of the phase.
- Latency: start sampled at edge N → valid=1 after edge N+2*(SETTLE+1). With default SETTLE=1 that is edge N+4; with SETTLE=0 it is edge N+2.
- sel_out rises on the LO→HI transition edge. en_n_out deasserts on the edge that enters HOLD.
- Handshake: the word is consumed on the edge where valid && ready. valid drops after that edge unless a new word completes on it; in this design that cannot happen before SETTLE+1 … 2*(SETTLE+1) further cycles.
- Throughput with ready tied high and start held high: one word per 2*(SETTLE+1)+1 cycles.

## Test plan
- Reset: hold rst_n=0, then release → sel_out=0, en_n_out=1, busy=0, valid=0, data_out=8'h00; no activity while start=0.
- Basic transfer, SETTLE=1: bench models the upstream '157 with a=4'b1010, b=4'b0101, driving y from sel_out/en_n_out. Pulse start → valid rises 4 cycles after the start edge, data_out=8'h5A. sel_out=0 for 2 cycles, then 1 for 2 cycles; en_n_out=0 for exactly 4 cycles.
- Backpressure: ready=0 for 10 cycles after valid → valid and data_out=8'h5A stay stable; start pulses during the wait are ignored. Raise ready → valid drops next edge, FSM returns to IDLE.
- Back-to-back: ready=1, start=1 continuously, a/b alternated between 1010/0101 and 0011/1100 → words 8'h5A then 8'hC3. Each valid lasts 1 cycle; period is 5 cycles.
- Disabled-bus check: force bus_in=4'b0000 whenever en_n_out=1 (upstream disabled) → captured nibbles never show zeros from the disabled window; data_out stays 8'h5A.
- Reset mid-operation: assert rst_n=0 during HI_WAIT → outputs take reset values asynchronously, valid never pulses. After release, a new start produces a correct word (8'h5A).
